// File: rtl/u_to_s_pipe.sv
`timescale 1ns/1ps
// u_to_s_pipe
//   Packs a sign + magnitude pair into a signed fraction for the FP adder
//   datapath. Two-stage valid/ready pipeline: S1 captures the input beat,
//   S2 computes and holds the result toward the adder input register.
//
//   Mode (exp_determine):
//     0 : two's-complement negate when sign=1 (-0 collapses to +0)
//     1 : realign, sign kept in MSB, magnitude shifted right by one,
//         inexact flags the discarded LSB
//
//   Ports
//     CLK, RST                    clock, synchronous active-high reset
//     in_valid / in_ready         input handshake (in_ready independent of in_valid)
//     sign, frac_unsigned         sign and FRAC_W-bit magnitude
//     exp_determine               mode select
//     out_valid / out_ready       output handshake
//     frac_signed                 FRAC_W+1 bit result
//     inexact                     mode 1 only: discarded LSB was 1
//     neg_zero                    only when U_TO_S_NEG_ZERO_EN is defined:
//                                 mode 0 input was -0
//
//   Build option: U_TO_S_NEG_ZERO_EN adds the neg_zero output.

module u_to_s_pipe #(
    parameter int unsigned FRAC_W = 26
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              sign,
    input  logic [FRAC_W-1:0] frac_unsigned,
    input  logic              exp_determine,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FRAC_W:0]   frac_signed,
    output logic              inexact
`ifdef U_TO_S_NEG_ZERO_EN
    ,
    output logic              neg_zero
`endif
);

    localparam int unsigned OUT_W = FRAC_W + 1;

    // Stage 1 state
    logic              s1_valid_q, s1_valid_d;
    logic              s1_sign_q,  s1_sign_d;
    logic [FRAC_W-1:0] s1_frac_q,  s1_frac_d;
    logic              s1_mode_q,  s1_mode_d;

    // Stage 2 state (drives the outputs directly)
    logic              s2_valid_q, s2_valid_d;
    logic [OUT_W-1:0]  res_q,      res_d;
    logic              inexact_q,  inexact_d;
    logic              neg_zero_q, neg_zero_d;

    logic              s1_adv;
    logic              in_xfer;
    logic [OUT_W-1:0]  mag_ext;

    // S2 can take a new beat when empty or when its beat leaves this cycle
    assign s1_adv   = !s2_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s1_adv;
    assign in_xfer  = in_valid && in_ready;
    assign mag_ext  = {1'b0, s1_frac_q};

    // Next-state for both stages
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_sign_d  = s1_sign_q;
        s1_frac_d  = s1_frac_q;
        s1_mode_d  = s1_mode_q;
        s2_valid_d = s2_valid_q;
        res_d      = res_q;
        inexact_d  = inexact_q;
        neg_zero_d = neg_zero_q;

        // S1 empties when it advances, refills on an input transfer
        if (s1_adv) begin
            s1_valid_d = 1'b0;
        end
        if (in_xfer) begin
            s1_valid_d = 1'b1;
            s1_sign_d  = sign;
            s1_frac_d  = frac_unsigned;
            s1_mode_d  = exp_determine;
        end

        if (s1_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                if (s1_mode_q) begin
                    res_d      = {s1_sign_q, 1'b0, s1_frac_q[FRAC_W-1:1]};
                    inexact_d  = s1_frac_q[0];
                    neg_zero_d = 1'b0;
                end else begin
                    // Magnitude < 2^FRAC_W, so the negation always fits
                    res_d      = s1_sign_q ? OUT_W'(~mag_ext + OUT_W'(1)) : mag_ext;
                    inexact_d  = 1'b0;
                    neg_zero_d = s1_sign_q && (s1_frac_q == '0);
                end
            end
        end
    end

    // State registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_frac_q  <= '0;
            s1_mode_q  <= 1'b0;
            s2_valid_q <= 1'b0;
            res_q      <= '0;
            inexact_q  <= 1'b0;
            neg_zero_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_sign_q  <= s1_sign_d;
            s1_frac_q  <= s1_frac_d;
            s1_mode_q  <= s1_mode_d;
            s2_valid_q <= s2_valid_d;
            res_q      <= res_d;
            inexact_q  <= inexact_d;
            neg_zero_q <= neg_zero_d;
        end
    end

    assign out_valid   = s2_valid_q;
    assign frac_signed = res_q;
    assign inexact     = inexact_q;

`ifdef U_TO_S_NEG_ZERO_EN
    assign neg_zero = neg_zero_q;
`else
    // -0 is folded into +0 and the flag has no consumer in this build
    logic unused_neg_zero;
    assign unused_neg_zero = neg_zero_q;
`endif

endmodule

// File: tb/tb_u_to_s_pipe.sv
`timescale 1ns/1ps
// tb_u_to_s_pipe
//   Directed vectors with hand-computed results for u_to_s_pipe: reset state,
//   latency, both modes, -0 handling, stall/backpressure streaming and
//   mid-flight reset.

module tb_u_to_s_pipe;

    logic        CLK = 1'b0;
    logic        RST;
    logic        in_valid;
    logic        in_ready;
    logic        sign;
    logic [25:0] frac_unsigned;
    logic        exp_determine;
    logic        out_valid;
    logic        out_ready;
    logic [26:0] frac_signed;
    logic        inexact;
`ifdef U_TO_S_NEG_ZERO_EN
    logic        neg_zero;
`endif

    int n_run  = 0;
    int n_fail = 0;

    u_to_s_pipe #(.FRAC_W(26)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .sign         (sign),
        .frac_unsigned(frac_unsigned),
        .exp_determine(exp_determine),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .frac_signed  (frac_signed),
        .inexact      (inexact)
`ifdef U_TO_S_NEG_ZERO_EN
        ,
        .neg_zero     (neg_zero)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; sampling point is 1ns after the rising edge
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Single beat with out_ready held 1: checks 2-cycle latency and one-shot output
    task automatic send_one(input string tag, input logic s, input logic [25:0] mag,
                            input logic mode, input logic [26:0] exp_frac,
                            input logic exp_inex, input logic exp_nz);
        out_ready     = 1'b1;
        in_valid      = 1'b1;
        sign          = s;
        frac_unsigned = mag;
        exp_determine = mode;
        #1;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        #1;
        check({tag, "_lat1_valid"}, 32'(out_valid), 32'd0);
        step();
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_frac"}, 32'(frac_signed), 32'(exp_frac));
        check({tag, "_inexact"}, 32'(inexact), 32'(exp_inex));
`ifdef U_TO_S_NEG_ZERO_EN
        check({tag, "_neg_zero"}, 32'(neg_zero), 32'(exp_nz));
`else
        if (exp_nz) check({tag, "_plus_zero"}, 32'(frac_signed), 32'd0);
`endif
        step();
        check({tag, "_popped"}, 32'(out_valid), 32'd0);
    endtask

    // Streaming beats: {sign, mag, mode} and expected {frac, inexact}
    logic        st_sign [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [25:0] st_mag  [4] = '{26'h012_3456, 26'h000_0010, 26'h000_0003, 26'h3FF_FFFE};
    logic        st_mode [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [26:0] st_frac [4] = '{27'h012_3456, 27'h7FF_FFF0, 27'h000_0001, 27'h5FF_FFFF};
    logic        st_inex [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        RST           = 1'b1;
        in_valid      = 1'b0;
        sign          = 1'b0;
        frac_unsigned = '0;
        exp_determine = 1'b0;
        out_ready     = 1'b0;
        step();
        step();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_frac", 32'(frac_signed), 32'd0);
        check("rst_inexact", 32'(inexact), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef U_TO_S_NEG_ZERO_EN
        check("rst_neg_zero", 32'(neg_zero), 32'd0);
`endif
        RST = 1'b0;
        step();

        send_one("m0_pos5",   1'b0, 26'h000_0005, 1'b0, 27'h000_0005, 1'b0, 1'b0);
        send_one("m0_neg1",   1'b1, 26'h000_0001, 1'b0, 27'h7FF_FFFF, 1'b0, 1'b0);
        send_one("m0_negmax", 1'b1, 26'h3FF_FFFF, 1'b0, 27'h400_0001, 1'b0, 1'b0);
        send_one("m1_neg",    1'b1, 26'h2AA_AAAB, 1'b1, 27'h555_5555, 1'b1, 1'b0);
        send_one("m1_pos",    1'b0, 26'h3FF_FFFF, 1'b1, 27'h1FF_FFFF, 1'b1, 1'b0);
        send_one("m0_negz",   1'b1, 26'h000_0000, 1'b0, 27'h000_0000, 1'b0, 1'b1);

        // Stream 4 beats with out_ready low on cycles 2-5
        begin
            int n_in  = 0;
            int n_out = 0;
            logic acc, pop;
            for (int cyc = 0; cyc < 20 && n_out < 4; cyc++) begin
                out_ready = !(cyc >= 2 && cyc <= 5);
                in_valid  = (n_in < 4);
                if (n_in < 4) begin
                    sign          = st_sign[n_in];
                    frac_unsigned = st_mag[n_in];
                    exp_determine = st_mode[n_in];
                end
                #1;
                if (cyc >= 2 && cyc <= 5) begin
                    check("st_stall_in_ready", 32'(in_ready), 32'd0);
                    check("st_stall_valid", 32'(out_valid), 32'd1);
                    check("st_stall_frac", 32'(frac_signed), 32'(st_frac[0]));
                end
                acc = in_valid && in_ready;
                pop = out_valid && out_ready;
                if (pop) begin
                    check("st_frac", 32'(frac_signed), 32'(st_frac[n_out]));
                    check("st_inexact", 32'(inexact), 32'(st_inex[n_out]));
                end
                step();
                if (acc) n_in++;
                if (pop) n_out++;
            end
            in_valid = 1'b0;
            check("st_beats_in", 32'(n_in), 32'd4);
            check("st_beats_out", 32'(n_out), 32'd4);
            #1;
            check("st_drained", 32'(out_valid), 32'd0);
        end

        // Reset with two beats in flight
        out_ready     = 1'b0;
        in_valid      = 1'b1;
        sign          = 1'b0;
        frac_unsigned = 26'h000_00AA;
        exp_determine = 1'b0;
        step();
        frac_unsigned = 26'h000_00BB;
        step();
        in_valid = 1'b0;
        #1;
        check("rst2_full_in_ready", 32'(in_ready), 32'd0);
        RST = 1'b1;
        step();
        RST = 1'b0;
        #1;
        check("rst2_out_valid", 32'(out_valid), 32'd0);
        check("rst2_in_ready", 32'(in_ready), 32'd1);
        check("rst2_frac", 32'(frac_signed), 32'd0);
        out_ready = 1'b1;
        begin
            int stale = 0;
            for (int i = 0; i < 4; i++) begin
                step();
                if (out_valid) stale++;
            end
            check("rst2_no_stale", 32'(stale), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
